// File: rtl/gf2m_reduce_if.sv
// Handshake bundle between the carry-less multiplier, the reduction stage and
// its consumer.
interface gf2m_reduce_if #(
    parameter int PW = 25,
    parameter int M  = 13
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/gf2m_reduce.sv
// Bit-serial GF(2^M) reduction of a (2M-1)-bit carry-less product modulo a
// fixed irreducible f(x); one coefficient folded per cycle, fixed latency.
module gf2m_reduce #(
    parameter int           PW   = 25,
    parameter int           M    = 13,
    parameter logic [M-1:0] POLY = 13'h001B
) (
    input  logic         clk,
    input  logic         rst,
    gf2m_reduce_if.slave bus
);
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;

    // Cancel coefficient x^pos using f(x)*x^(pos-M); pos is always >= M here.
    function automatic logic [PW-1:0] fold_step(input logic [PW-1:0] a,
                                                input logic [CW-1:0] pos);
        logic [PW-1:0] f_ext;
        f_ext = PW'({1'b1, POLY});
        if (a[pos])
            return a ^ (f_ext << (pos - CW'(M)));
        else
            return a;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = REDUCE;
            REDUCE:  if (cnt == CW'(M)) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every REDUCE cycle folds unconditionally so latency never depends on data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc <= bus.in_data;
                        cnt <= CW'(PW - 1);
                    end
                end
                REDUCE: begin
                    acc <= fold_step(acc, cnt);
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result is masked outside DONE so a partially reduced value never leaks.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_data  = (state == DONE) ? acc[M-1:0] : '0;
    end
endmodule
